// File: rtl/reg_file_bank.sv
// reg_file_bank: general-purpose register file, one byte-lane-masked write
// port, two combinational read ports, saturating committed-write counter.
// Ports: clk, rst_n (async, active-low), we, wbe, waddr, wdata,
//        raddr_a/rdata_a, raddr_b/rdata_b, wr_count.
// Option: define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_bank #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 ZERO_REG = 1,
  parameter logic [DATA_W-1:0]  RST_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [ADDR_W-1:0]     raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [ADDR_W-1:0]     raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  output logic [15:0]           wr_count
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("reg_file_bank: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [15:0]       r_wr_count;
  logic              w_r0_sup;
  logic              w_commit;

  // Writes to r0 are dropped entirely when it is hardwired to zero.
  assign w_r0_sup = (ZERO_REG != 0) && (waddr == '0);
  assign w_commit = we && (|wbe) && !w_r0_sup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RST_VAL;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign wr_count = r_wr_count;

`ifdef REGFILE_BYPASS_EN
  logic [DATA_W-1:0] w_merged;

  // Value the target register will hold after this edge.
  always_comb begin
    w_merged = r_mem[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        w_merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_a = r_mem[raddr_a];
    if (w_commit && (raddr_a == waddr)) begin
      rdata_a = w_merged;
    end
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      rdata_a = '0;
    end
  end

  always_comb begin
    rdata_b = r_mem[raddr_b];
    if (w_commit && (raddr_b == waddr)) begin
      rdata_b = w_merged;
    end
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      rdata_b = '0;
    end
  end
`else
  always_comb begin
    rdata_a = r_mem[raddr_a];
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      rdata_a = '0;
    end
  end

  always_comb begin
    rdata_b = r_mem[raddr_b];
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      rdata_b = '0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: directed self-checking bench for reg_file_bank.
// Default parameters; expectations follow REGFILE_BYPASS_EN if defined.
`timescale 1ns/10ps
module tb_reg_file_bank;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wbe;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;
  logic [15:0] wr_count;

  int checks;
  int failures;
  logic [15:0] exp_cnt;

  reg_file_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wbe      (wbe),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a,
                          input logic [3:0] be,
                          input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wbe   = be;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    do_write(5'd3, 4'hF, 32'h12345678);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #0.2;
    for (int i = 0; i < 32; i++) begin
      raddr_a = i[4:0];
      raddr_b = 5'(31 - i);
      #0.1;
      checks++;
      if (rdata_a !== 32'h0) begin
        failures++;
        $display("FAIL reset_a[%0d] got=%h exp=0", i, rdata_a);
      end
      checks++;
      if (rdata_b !== 32'h0) begin
        failures++;
        $display("FAIL reset_b[%0d] got=%h exp=0", 31 - i, rdata_b);
      end
    end
    checks++;
    if (wr_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_cnt got=%h exp=0", wr_count);
    end
    // A write attempted while reset is held must be lost.
    we    = 1'b1;
    waddr = 5'd3;
    wbe   = 4'hF;
    wdata = 32'hCAFEF00D;
    raddr_a = 5'd3;
    @(posedge clk);
    #1;
    checks++;
    if (rdata_a !== 32'h0) begin
      failures++;
      $display("FAIL reset_wins got=%h exp=0", rdata_a);
    end
    checks++;
    if (wr_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_wins_cnt got=%h exp=0", wr_count);
    end
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'h0;
  endtask

  task automatic test_full_write;
    do_write(5'd5, 4'hF, 32'hDEADBEEF);
    exp_cnt++;
    raddr_a = 5'd5;
    raddr_b = 5'd5;
    #1;
    checks++;
    if (rdata_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL full_a got=%h exp=deadbeef", rdata_a);
    end
    checks++;
    if (rdata_b !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL full_b got=%h exp=deadbeef", rdata_b);
    end
    checks++;
    if (wr_count !== 16'd1) begin
      failures++;
      $display("FAIL full_cnt got=%h exp=1", wr_count);
    end
  endtask

  task automatic test_byte_lanes;
    do_write(5'd5, 4'b0101, 32'h11223344);
    exp_cnt++;
    raddr_a = 5'd5;
    #1;
    checks++;
    if (rdata_a !== 32'hDE22BE44) begin
      failures++;
      $display("FAIL lanes got=%h exp=de22be44", rdata_a);
    end
    // Enable with no lanes selected: nothing changes, nothing counted.
    do_write(5'd5, 4'b0000, 32'h00000000);
    #1;
    checks++;
    if (rdata_a !== 32'hDE22BE44) begin
      failures++;
      $display("FAIL lanes_none got=%h exp=de22be44", rdata_a);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      failures++;
      $display("FAIL lanes_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_zero_reg;
    do_write(5'd0, 4'hF, 32'hFFFFFFFF);
    raddr_a = 5'd0;
    raddr_b = 5'd0;
    #1;
    checks++;
    if (rdata_a !== 32'h0) begin
      failures++;
      $display("FAIL zero_a got=%h exp=0", rdata_a);
    end
    checks++;
    if (rdata_b !== 32'h0) begin
      failures++;
      $display("FAIL zero_b got=%h exp=0", rdata_b);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      failures++;
      $display("FAIL zero_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_wc;
`ifdef REGFILE_BYPASS_EN
    exp_wc = 32'hA5A5A5A5;
`else
    exp_wc = 32'h0;
`endif
    @(negedge clk);
    we      = 1'b1;
    waddr   = 5'd7;
    wbe     = 4'hF;
    wdata   = 32'hA5A5A5A5;
    raddr_a = 5'd7;
    raddr_b = 5'd5;
    #1;
    checks++;
    if (rdata_a !== exp_wc) begin
      failures++;
      $display("FAIL rdw_same got=%h exp=%h", rdata_a, exp_wc);
    end
    checks++;
    if (rdata_b !== 32'hDE22BE44) begin
      failures++;
      $display("FAIL rdw_other got=%h exp=de22be44", rdata_b);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    exp_cnt++;
    checks++;
    if (rdata_a !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL rdw_next got=%h exp=a5a5a5a5", rdata_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    vals[0] = 32'h01020304;
    vals[1] = 32'hF0E0D0C0;
    vals[2] = 32'h00FF00FF;
    vals[3] = 32'h80000001;
    @(negedge clk);
    we  = 1'b1;
    wbe = 4'hF;
    for (int i = 0; i < 4; i++) begin
      waddr = 5'(10 + i);
      wdata = vals[i];
      @(negedge clk);
    end
    we = 1'b0;
    exp_cnt = exp_cnt + 16'd4;
    for (int i = 0; i < 4; i++) begin
      raddr_a = 5'(10 + i);
      raddr_b = 5'(13 - i);
      #1;
      checks++;
      if (rdata_a !== vals[i]) begin
        failures++;
        $display("FAIL b2b_a[%0d] got=%h exp=%h", i, rdata_a, vals[i]);
      end
      checks++;
      if (rdata_b !== vals[3-i]) begin
        failures++;
        $display("FAIL b2b_b[%0d] got=%h exp=%h", i, rdata_b, vals[3-i]);
      end
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      failures++;
      $display("FAIL b2b_cnt got=%h exp=%h", wr_count, exp_cnt);
    end
  endtask

  task automatic test_saturation;
    int n;
    n = 16'hFFFE - exp_cnt;
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd1;
    wbe   = 4'h1;
    wdata = 32'h5A;
    repeat (n) @(posedge clk);
    #1;
    we = 1'b0;
    checks++;
    if (wr_count !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_pre got=%h exp=fffe", wr_count);
    end
    do_write(5'd2, 4'hF, 32'h1);
    checks++;
    if (wr_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_1 got=%h exp=ffff", wr_count);
    end
    do_write(5'd2, 4'hF, 32'h2);
    do_write(5'd2, 4'hF, 32'h3);
    checks++;
    if (wr_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h exp=ffff", wr_count);
    end
    raddr_a = 5'd2;
    #1;
    checks++;
    if (rdata_a !== 32'h3) begin
      failures++;
      $display("FAIL sat_data got=%h exp=3", rdata_a);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'h0;
    rst_n    = 1'b0;
    we       = 1'b0;
    wbe      = 4'h0;
    waddr    = 5'd0;
    wdata    = 32'h0;
    raddr_a  = 5'd0;
    raddr_b  = 5'd0;
    #12 rst_n = 1'b1;
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
